// File: rtl/aes_kat_bist_if.sv
// Bus bundle between the known-answer BIST and its environment: table load
// port, run control, the AES core drive/return path and the result status.
interface aes_kat_bist_if #(
  parameter int AW = 2
);
  logic         load_we;
  logic [AW-1:0] load_addr;
  logic [127:0] load_pt;
  logic [127:0] load_key;
  logic [127:0] load_ct;
  logic         start;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         busy;
  logic         done;
  logic         pass;
  logic [15:0]  err_cnt;
  logic [AW-1:0] first_err_idx;
  logic         first_err_vld;

  modport master (
    output load_we, load_addr, load_pt, load_key, load_ct, start, core_out,
    input  core_state, core_key, busy, done, pass, err_cnt, first_err_idx, first_err_vld
  );

  modport slave (
    input  load_we, load_addr, load_pt, load_key, load_ct, start, core_out,
    output core_state, core_key, busy, done, pass, err_cnt, first_err_idx, first_err_vld
  );
endinterface

// File: rtl/aes_kat_bist.sv
// Known-answer self-test for a pipelined AES-128 core: streams a loadable
// vector table into the core and checks each ciphertext LATENCY cycles later.
module aes_kat_bist #(
  parameter int NUM_VEC = 4,
  parameter int LATENCY = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  aes_kat_bist_if.slave bus
);
  localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_VEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [127:0]   core_state_q, core_state_d;
  logic [127:0]   core_key_q, core_key_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [AW-1:0]  first_err_idx_q, first_err_idx_d;
  logic           first_err_vld_q, first_err_vld_d;

  logic           trk_vld_q [LATENCY];
  logic [AW-1:0]  trk_idx_q [LATENCY];
  logic           push_vld;

  logic [127:0]   mem_pt  [NUM_VEC];
  logic [127:0]   mem_key [NUM_VEC];
  logic [127:0]   mem_ct  [NUM_VEC];

  logic           idle_like;
  logic           load_ok;
  logic           cmp_vld;
  logic [AW-1:0]  cmp_idx;
  logic           mismatch;
  logic [AW-1:0]  idx_inc;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign load_ok   = idle_like && bus.load_we && (32'(bus.load_addr) < NUM_VEC);
  assign cmp_vld   = trk_vld_q[LATENCY-1];
  assign cmp_idx   = trk_idx_q[LATENCY-1];
  assign mismatch  = cmp_vld && (bus.core_out != mem_ct[cmp_idx]);
  assign idx_inc   = idx_q + AW'(1);

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem_pt[bus.load_addr]  <= bus.load_pt;
      mem_key[bus.load_addr] <= bus.load_key;
      mem_ct[bus.load_addr]  <= bus.load_ct;
    end
  end

  // The core input register is loaded one edge ahead of the ISSUE cycle it
  // belongs to, so vector k is on the core while idx_q == k.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    core_state_d    = '0;
    core_key_d      = '0;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    push_vld        = 1'b0;

    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (!first_err_vld_q) begin
        first_err_idx_d = cmp_idx;
        first_err_vld_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d         = S_ISSUE;
          idx_d           = '0;
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          first_err_vld_d = 1'b0;
          core_state_d    = mem_pt[0];
          core_key_d      = mem_key[0];
        end
      end
      S_ISSUE: begin
        push_vld = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          idx_d        = idx_inc;
          core_state_d = mem_pt[idx_inc];
          core_key_d   = mem_key[idx_inc];
        end
      end
      S_DRAIN: begin
        if (cmp_vld && (cmp_idx == LAST_IDX)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      core_state_q    <= '0;
      core_key_q      <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      core_state_q    <= core_state_d;
      core_key_q      <= core_key_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  // Tracking line: entry issued at the end of cycle c reaches the last stage
  // in cycle c+LATENCY, aligned with the core's matching output.
  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_trk
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          trk_vld_q[gi] <= 1'b0;
          trk_idx_q[gi] <= '0;
        end else if (gi == 0) begin
          trk_vld_q[gi] <= push_vld;
          trk_idx_q[gi] <= idx_q;
        end else begin
          trk_vld_q[gi] <= trk_vld_q[(gi > 0) ? gi - 1 : 0];
          trk_idx_q[gi] <= trk_idx_q[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign bus.core_state    = core_state_q;
  assign bus.core_key      = core_key_q;
  assign bus.busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done          = (state_q == S_DONE);
  assign bus.pass          = (state_q == S_DONE) && (err_cnt_q == 16'd0);
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_idx = first_err_idx_q;
  assign bus.first_err_vld = first_err_vld_q;
endmodule

// File: tb/tb_aes_kat_bist.sv
// Bench for aes_kat_bist: a delay-line core model, a table of fault patterns
// on the FIPS-197 vector, run-disturb/reset sequences and randomized tables.
module tb_aes_kat_bist;
  localparam int N  = 4;
  localparam int L  = 20;
  localparam int AW = 2;

  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_kat_bist_if #(.AW(AW)) bus();

  aes_kat_bist #(.NUM_VEC(N), .LATENCY(L)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Stand-in for the AES core: FIPS vector answers correctly, anything else
  // gets a cheap keyed scramble; output appears L cycles after the input.
  function automatic logic [127:0] fcore(input logic [127:0] s, input logic [127:0] k);
    if (s == FPT && k == FKEY) return FCT;
    return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  logic [127:0] pipe [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= fcore(bus.core_state, bus.core_key);
  end
  assign bus.core_out = pipe[L-1];

  int tests = 0;
  int fails = 0;
  int run_no = 0;
  logic [127:0] m_pt [N];
  logic [127:0] m_key[N];
  logic [127:0] m_ct [N];

  typedef struct {
    logic [3:0] bad;
    int         exp_err;
    int         exp_first;
  } scen_t;
  scen_t scen [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct);
    bus.load_we   = 1'b1;
    bus.load_addr = AW'(a);
    bus.load_pt   = pt;
    bus.load_key  = key;
    bus.load_ct   = ct;
    tick();
    bus.load_we = 1'b0;
    m_pt[a]  = pt;
    m_key[a] = key;
    m_ct[a]  = ct;
  endtask

  task automatic model_expect(output int e_err, output int e_first);
    e_err = 0;
    e_first = -1;
    for (int k = 0; k < N; k++) begin
      if (fcore(m_pt[k], m_key[k]) != m_ct[k]) begin
        if (e_first < 0) e_first = k;
        e_err++;
      end
    end
  endtask

  // mode 1 pokes start and a table write into the middle of the run.
  task automatic run(input int mode, input int e_err, input int e_first);
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_done_clr", bus.done, 0);
    chk("start_pass_clr", bus.pass, 0);
    chk("start_err_clr", bus.err_cnt, 0);
    chk("start_fvld_clr", bus.first_err_vld, 0);
    n = 0;
    while (!bus.done && n < 100) begin
      if (n < N) begin
        chk("core_state", bus.core_state, m_pt[n]);
        chk("core_key", bus.core_key, m_key[n]);
      end
      if (n == N) chk("core_state_drain", bus.core_state, 0);
      if (n == N + L - 1) chk("busy_drain", bus.busy, 1);
      if (mode == 1 && n == 4) bus.start = 1'b1;
      if (mode == 1 && n == 5) begin
        bus.start     = 1'b0;
        bus.load_we   = 1'b1;
        bus.load_addr = '0;
        bus.load_ct   = '0;
      end
      if (mode == 1 && n == 6) bus.load_we = 1'b0;
      tick();
      n++;
    end
    chk("done_latency", n, N + L);
    chk("done", bus.done, 1);
    chk("busy_end", bus.busy, 0);
    chk("pass", bus.pass, (e_err == 0));
    chk("err_cnt", bus.err_cnt, e_err);
    chk("first_err_vld", bus.first_err_vld, (e_err != 0));
    if (e_err != 0) chk("first_err_idx", bus.first_err_idx, e_first);
    run_no++;
    $display("[TB] run %0d mode %0d: err_cnt=%0d first_idx=%0d pass=%0d latency=%0d",
             run_no, mode, bus.err_cnt, bus.first_err_idx, bus.pass, n);
  endtask

  initial begin
    int e_err, e_first;
    logic [127:0] flip;
    scen[0] = '{4'b0000, 0, 0};
    scen[1] = '{4'b1010, 2, 1};
    scen[2] = '{4'b1111, 4, 0};
    scen[3] = '{4'b1000, 1, 3};
    scen[4] = '{4'b0100, 1, 2};

    bus.start = 0; bus.load_we = 0; bus.load_addr = '0;
    bus.load_pt = '0; bus.load_key = '0; bus.load_ct = '0;

    // Reset held with inputs toggling
    for (int c = 0; c < 3; c++) begin
      bus.start   = c[0];
      bus.load_we = ~c[0];
      tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pass", bus.pass, 0);
      chk("rst_core_state", bus.core_state, 0);
      chk("rst_err", {bus.err_cnt, bus.first_err_vld, bus.first_err_idx}, 0);
    end
    bus.start = 0; bus.load_we = 0;
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < N; k++) load(k, FPT, FKEY, FCT);
    run(0, 0, 0);

    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < N; k++)
        load(k, FPT, FKEY, scen[s].bad[k] ? (FCT ^ 128'h1) : FCT);
      run(0, scen[s].exp_err, scen[s].exp_first);
    end

    // Correct entry 2 while in DONE and rerun back-to-back
    load(2, FPT, FKEY, FCT);
    run(0, 0, 0);

    // start/load during busy must be ignored, table intact on rerun
    run(1, 0, 0);
    run(0, 0, 0);

    // Reset mid-run
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_core", bus.core_state, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {bus.busy, bus.done}, 0);
    run(0, 0, 0);

    // Randomized tables against the model
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        logic [127:0] pt, key;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        flip = '0;
        if ($urandom_range(0, 2) == 0) flip[$urandom_range(0, 127)] = 1'b1;
        load(k, pt, key, fcore(pt, key) ^ flip);
      end
      model_expect(e_err, e_first);
      run(0, e_err, e_first);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
